flexbex_efpga_bridge: RTL and testbench
=======================================

# flexbex_efpga_bridge

Sequencing bridge between the core's EX stage and the eFPGA fabric. It captures the operands and operator when the EX stage raises its eFPGA write strobe, launches the fabric with a one-cycle start pulse, and waits for the fabric's done flag or a programmable timeout. It then holds the three fabric result words and a level `done_o` stable for the EX stage's eFPGA unit to consume.

## Interface
Parameters:
- `TIMEOUT_W`, default 8: width of the timeout counter and `timeout_cycles_i`.

Ports (clock and reset first; reset is synchronous and active-low):
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `write_strobe_i`  in  1  EX-stage eFPGA write strobe; a one-cycle launch request.
- `operator_i`  in  2  eFPGA operator; captured on an accepted strobe.
- `operand_a_i`, `operand_b_i`  in  32 each  operands; captured on an accepted strobe.
- `timeout_cycles_i`  in  TIMEOUT_W  WAIT-cycle limit; 0 disables the timeout.
- `fpga_operator_o`  out  2  registered operator to the fabric.
- `fpga_op_a_o`, `fpga_op_b_o`  out  32 each  registered operands to the fabric.
- `fpga_start_o`  out  1  one-cycle launch pulse to the fabric.
- `fpga_done_i`  in  1  fabric completion, synchronous to `clk`, sampled only in WAIT.
- `fpga_res_a_i`, `fpga_res_b_i`, `fpga_res_c_i`  in  32 each  fabric results.
- `result_a_o`, `result_b_o`, `result_c_o`  out  32 each  held results to the EX-stage eFPGA unit.
- `done_o`  out  1  results valid; a level signal.
- `busy_o`  out  1  high in LAUNCH or WAIT.
- `timeout_o`  out  1  the last operation ended by timeout; valid while `done_o`=1.
- `overrun_o`  out  1  sticky: a strobe arrived while busy; cleared only by reset.

## Operation
- States: IDLE, LAUNCH, WAIT, DONE; 2-bit encoding; reset state IDLE.
- IDLE:
  - `write_strobe_i`=1 → capture `operator_i`, `operand_a_i` and `operand_b_i` into the `fpga_*_o` registers, then go to LAUNCH.
- LAUNCH:
  - `fpga_start_o`=1 for exactly this cycle.
  - Clear the timeout counter, clear `timeout_o`, then go to WAIT.
- WAIT:
  - The counter increments every cycle that `fpga_done_i`=0.
  - `fpga_done_i`=1 → latch `fpga_res_a/b/c_i` into `result_a/b/c_o`, set `timeout_o`=0, go to DONE.
  - Otherwise, if `timeout_cycles_i`≠0 and the counter equals `timeout_cycles_i`-1 → set all three results to 32'hFFFF_FFFF, set `timeout_o`=1, go to DONE.
  - If done and timeout occur in the same cycle, done wins.
  - The counter saturates at all-ones; it never wraps.
- DONE:
  - `done_o`=1; results and `timeout_o` are held stable.
  - `write_strobe_i`=1 → drop `done_o` the next cycle, capture the new operands, go to LAUNCH. This is back-to-back relaunch; it does not pass through IDLE.
- Strobe in LAUNCH or WAIT: ignored; captured operands are unchanged; `overrun_o` is set.
- `fpga_done_i` outside WAIT is ignored.
- `busy_o` = (state==LAUNCH) or (state==WAIT).

## Timing
- Reset values (applied when `rst_n`=0 at a rising edge, from any state, including mid-WAIT):
  - State IDLE; counter 0.
  - `fpga_start_o`=0, `done_o`=0, `busy_o`=0, `timeout_o`=0, `overrun_o`=0.
  - All operand, operator and result registers 0.
- Reset mid-operation discards the operation; a `fpga_done_i` arriving after reset is ignored.
- Latency with done, where strobe is sampled at edge N:
  - `fpga_start_o` is high in cycle N+1 (LAUNCH).
  - WAIT begins at N+2.
  - `fpga_done_i` sampled high at edge M → results and `done_o` visible from cycle M+1.
  - Minimum strobe-to-`done_o` is 3 cycles (done high in the first WAIT cycle).
- Timeout:
  - With `timeout_cycles_i`=T≠0, WAIT lasts exactly T cycles.
  - `done_o` rises T+2 cycles after the strobe-sampling edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Basic:
  - Stimulus: strobe with `operator_i`=2, `operand_a_i`=0x1234_5678, `operand_b_i`=0x9ABC_DEF0; `fpga_done_i` high 3 cycles after `fpga_start_o`, with results 0x11/0x22/0x33.
  - Response: `fpga_op_*_o` match the operands; exactly one start pulse; `done_o`=1 with results 0x11/0x22/0x33; `timeout_o`=0.
- Timeout:
  - Stimulus: `timeout_cycles_i`=5, `fpga_done_i` held 0.
  - Response: WAIT lasts exactly 5 cycles; results 0xFFFF_FFFF; `timeout_o`=1; `done_o`=1.
- Done/timeout collision:
  - Stimulus: `timeout_cycles_i`=4, `fpga_done_i` asserted in the 4th WAIT cycle.
  - Response: fabric results latched; `timeout_o`=0.
- Overrun:
  - Stimulus: second strobe with new operands during WAIT.
  - Response: operands unchanged; `overrun_o`=1 and it stays 1; the operation completes normally.
- Relaunch from DONE:
  - Stimulus: strobe while `done_o`=1.
  - Response: `done_o` drops next cycle; new start pulse follows; new results replace the old.
- Reset mid-WAIT:
  - Stimulus: `rst_n`=0 for one edge during WAIT, then `fpga_done_i`=1.
  - Response: all outputs 0, state IDLE; the late done is ignored.

Source files
------------

// File: rtl/flexbex_efpga_bridge.sv
// Sequencing bridge between the EX stage and the eFPGA fabric: captures operands,
// pulses start, then waits for fabric done or a programmable timeout and holds results.
module flexbex_efpga_bridge #(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 write_strobe_i,
  input  logic [1:0]           operator_i,
  input  logic [31:0]          operand_a_i,
  input  logic [31:0]          operand_b_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic [1:0]           fpga_operator_o,
  output logic [31:0]          fpga_op_a_o,
  output logic [31:0]          fpga_op_b_o,
  output logic                 fpga_start_o,
  input  logic                 fpga_done_i,
  input  logic [31:0]          fpga_res_a_i,
  input  logic [31:0]          fpga_res_b_i,
  input  logic [31:0]          fpga_res_c_i,
  output logic [31:0]          result_a_o,
  output logic [31:0]          result_b_o,
  output logic [31:0]          result_c_o,
  output logic                 done_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 overrun_o
);

  // state  | meaning
  // IDLE   | no operation, waiting for a write strobe
  // LAUNCH | operands captured, start pulse to the fabric
  // WAIT   | counting cycles until fabric done or timeout
  // DONE   | results and timeout flag held for the EX stage
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 capture;
  logic                 latch_res;
  logic                 latch_to;
  logic                 to_hit;

  assign to_hit = (timeout_cycles_i != '0) &&
                  (cnt_q == timeout_cycles_i - TIMEOUT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    latch_res = 1'b0;
    latch_to  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (write_strobe_i) begin
          capture = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        // fabric done takes priority over a timeout in the same cycle
        if (fpga_done_i) begin
          latch_res = 1'b1;
          state_d   = S_DONE;
        end else if (to_hit) begin
          latch_to = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (write_strobe_i) begin
          capture = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q           <= '0;
      fpga_operator_o <= '0;
      fpga_op_a_o     <= '0;
      fpga_op_b_o     <= '0;
      result_a_o      <= '0;
      result_b_o      <= '0;
      result_c_o      <= '0;
      timeout_o       <= 1'b0;
      overrun_o       <= 1'b0;
    end else begin
      if (capture) begin
        fpga_operator_o <= operator_i;
        fpga_op_a_o     <= operand_a_i;
        fpga_op_b_o     <= operand_b_i;
      end
      if (state_q == S_LAUNCH) begin
        cnt_q     <= '0;
        timeout_o <= 1'b0;
      end else if (state_q == S_WAIT && !fpga_done_i && cnt_q != '1) begin
        cnt_q <= cnt_q + TIMEOUT_W'(1);
      end
      if (latch_res) begin
        result_a_o <= fpga_res_a_i;
        result_b_o <= fpga_res_b_i;
        result_c_o <= fpga_res_c_i;
        timeout_o  <= 1'b0;
      end else if (latch_to) begin
        result_a_o <= '1;
        result_b_o <= '1;
        result_c_o <= '1;
        timeout_o  <= 1'b1;
      end
      if (write_strobe_i && (state_q == S_LAUNCH || state_q == S_WAIT))
        overrun_o <= 1'b1;
    end
  end

  // decoded straight from the state register, so no input reaches these combinationally
  assign fpga_start_o = (state_q == S_LAUNCH);
  assign busy_o       = (state_q == S_LAUNCH) || (state_q == S_WAIT);
  assign done_o       = (state_q == S_DONE);

endmodule

// File: tb/tb_flexbex_efpga_bridge.sv
// Self-checking bench for flexbex_efpga_bridge: scenario tasks with a result scoreboard.
module tb_flexbex_efpga_bridge;

  logic        clk;
  logic        rst_n;
  logic        write_strobe_i;
  logic [1:0]  operator_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic [7:0]  timeout_cycles_i;
  logic [1:0]  fpga_operator_o;
  logic [31:0] fpga_op_a_o, fpga_op_b_o;
  logic        fpga_start_o;
  logic        fpga_done_i;
  logic [31:0] fpga_res_a_i, fpga_res_b_i, fpga_res_c_i;
  logic [31:0] result_a_o, result_b_o, result_c_o;
  logic        done_o, busy_o, timeout_o, overrun_o;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        to;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;

  flexbex_efpga_bridge #(.TIMEOUT_W(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .write_strobe_i   (write_strobe_i),
    .operator_i       (operator_i),
    .operand_a_i      (operand_a_i),
    .operand_b_i      (operand_b_i),
    .timeout_cycles_i (timeout_cycles_i),
    .fpga_operator_o  (fpga_operator_o),
    .fpga_op_a_o      (fpga_op_a_o),
    .fpga_op_b_o      (fpga_op_b_o),
    .fpga_start_o     (fpga_start_o),
    .fpga_done_i      (fpga_done_i),
    .fpga_res_a_i     (fpga_res_a_i),
    .fpga_res_b_i     (fpga_res_b_i),
    .fpga_res_c_i     (fpga_res_c_i),
    .result_a_o       (result_a_o),
    .result_b_o       (result_b_o),
    .result_c_o       (result_c_o),
    .done_o           (done_o),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .overrun_o        (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    write_strobe_i = 1'b1;
    operator_i     = op;
    operand_a_i    = a;
    operand_b_i    = b;
    tick();
    write_strobe_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tests++;
    if ({fpga_start_o, done_o, busy_o, timeout_o, overrun_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 00000",
               {fpga_start_o, done_o, busy_o, timeout_o, overrun_o});
    end
    tests++;
    if ({fpga_operator_o, fpga_op_a_o, fpga_op_b_o, result_a_o, result_b_o, result_c_o} !== '0) begin
      fails++;
      $display("FAIL reset_regs: op=%h a=%h b=%h ra=%h rb=%h rc=%h want all 0",
               fpga_operator_o, fpga_op_a_o, fpga_op_b_o, result_a_o, result_b_o, result_c_o);
    end
  endtask

  task automatic test_basic();
    int starts;
    timeout_cycles_i = 8'd0;
    strobe(2'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    exp_q.push_back('{a: 32'h11, b: 32'h22, c: 32'h33, to: 1'b0});
    starts = fpga_start_o ? 1 : 0;
    tests++;
    if ({fpga_operator_o, fpga_op_a_o, fpga_op_b_o} !== {2'd2, 32'h1234_5678, 32'h9ABC_DEF0}) begin
      fails++;
      $display("FAIL basic_operands: got %h %h %h want 2 12345678 9abcdef0",
               fpga_operator_o, fpga_op_a_o, fpga_op_b_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (fpga_start_o) starts++;
    end
    fpga_done_i  = 1'b1;
    fpga_res_a_i = 32'h11;
    fpga_res_b_i = 32'h22;
    fpga_res_c_i = 32'h33;
    tick();
    if (fpga_start_o) starts++;
    fpga_done_i = 1'b0;
    tests++;
    if (starts !== 1) begin
      fails++;
      $display("FAIL basic_start_count: got %0d want 1", starts);
    end
    tests++;
    if (done_o !== 1'b1) begin
      fails++;
      $display("FAIL basic_done_latency: done_o got %b want 1", done_o);
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL basic_scoreboard: queue empty want 1 entry");
    end else begin
      e = exp_q.pop_front();
      if ({result_a_o, result_b_o, result_c_o, timeout_o} !== {e.a, e.b, e.c, e.to}) begin
        fails++;
        $display("FAIL basic_results: got %h %h %h to=%b want %h %h %h to=%b",
                 result_a_o, result_b_o, result_c_o, timeout_o, e.a, e.b, e.c, e.to);
      end
    end
    tick();
    tests++;
    if (done_o !== 1'b1 || result_a_o !== 32'h11) begin
      fails++;
      $display("FAIL basic_hold: done=%b ra=%h want 1 00000011", done_o, result_a_o);
    end
  endtask

  task automatic test_timeout();
    int ticks;
    int wait_cycles;
    timeout_cycles_i = 8'd5;
    strobe(2'd1, 32'hCAFE_0001, 32'hCAFE_0002);
    exp_q.push_back('{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, c: 32'hFFFF_FFFF, to: 1'b1});
    ticks = 1;
    wait_cycles = 0;
    while (!done_o && ticks < 40) begin
      if (busy_o && !fpga_start_o) wait_cycles++;
      tick();
      ticks++;
    end
    tests++;
    if (!done_o) begin
      fails++;
      $display("FAIL timeout_wait_expired: done_o never rose in %0d cycles", ticks);
    end
    tests++;
    if (wait_cycles !== 5) begin
      fails++;
      $display("FAIL timeout_wait_len: got %0d WAIT cycles want 5", wait_cycles);
    end
    tests++;
    if (ticks !== 7) begin
      fails++;
      $display("FAIL timeout_latency: done after %0d cycles want 7", ticks);
    end
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL timeout_scoreboard: queue empty want 1 entry");
    end else begin
      e = exp_q.pop_front();
      if ({result_a_o, result_b_o, result_c_o, timeout_o} !== {e.a, e.b, e.c, e.to}) begin
        fails++;
        $display("FAIL timeout_results: got %h %h %h to=%b want %h %h %h to=%b",
                 result_a_o, result_b_o, result_c_o, timeout_o, e.a, e.b, e.c, e.to);
      end
    end
  endtask

  task automatic test_collision();
    timeout_cycles_i = 8'd4;
    strobe(2'd3, 32'h0000_00C1, 32'h0000_00C2);
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL collision_in_wait: busy=%b done=%b want 1 0", busy_o, done_o);
    end
    fpga_done_i  = 1'b1;
    fpga_res_a_i = 32'hA1;
    fpga_res_b_i = 32'hA2;
    fpga_res_c_i = 32'hA3;
    exp_q.push_back('{a: 32'hA1, b: 32'hA2, c: 32'hA3, to: 1'b0});
    tick();
    fpga_done_i = 1'b0;
    tests++;
    if (exp_q.size() == 0 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL collision_done: done=%b queue=%0d want 1 1", done_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({result_a_o, result_b_o, result_c_o, timeout_o} !== {e.a, e.b, e.c, e.to}) begin
        fails++;
        $display("FAIL collision_results: got %h %h %h to=%b want %h %h %h to=%b",
                 result_a_o, result_b_o, result_c_o, timeout_o, e.a, e.b, e.c, e.to);
      end
    end
  endtask

  task automatic test_overrun();
    timeout_cycles_i = 8'd0;
    tests++;
    if (overrun_o !== 1'b0) begin
      fails++;
      $display("FAIL overrun_initial: got %b want 0", overrun_o);
    end
    strobe(2'd1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
    tick();
    strobe(2'd3, 32'h5555_5555, 32'h6666_6666);
    tests++;
    if ({fpga_operator_o, fpga_op_a_o, fpga_op_b_o, overrun_o} !==
        {2'd1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1}) begin
      fails++;
      $display("FAIL overrun_capture: got %h %h %h ovr=%b want 1 aaaaaaaa bbbbbbbb ovr=1",
               fpga_operator_o, fpga_op_a_o, fpga_op_b_o, overrun_o);
    end
    fpga_done_i  = 1'b1;
    fpga_res_a_i = 32'h44;
    fpga_res_b_i = 32'h45;
    fpga_res_c_i = 32'h46;
    exp_q.push_back('{a: 32'h44, b: 32'h45, c: 32'h46, to: 1'b0});
    tick();
    fpga_done_i = 1'b0;
    tests++;
    if (exp_q.size() == 0 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun_done: done=%b queue=%0d want 1 1", done_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({result_a_o, result_b_o, result_c_o, timeout_o} !== {e.a, e.b, e.c, e.to}) begin
        fails++;
        $display("FAIL overrun_results: got %h %h %h to=%b want %h %h %h to=%b",
                 result_a_o, result_b_o, result_c_o, timeout_o, e.a, e.b, e.c, e.to);
      end
    end
    tests++;
    if (overrun_o !== 1'b1) begin
      fails++;
      $display("FAIL overrun_sticky: got %b want 1", overrun_o);
    end
  endtask

  task automatic test_back_to_back();
    strobe(2'd0, 32'h0000_0055, 32'h0000_0066);
    tests++;
    if ({done_o, fpga_start_o, fpga_op_a_o, fpga_op_b_o} !== {1'b0, 1'b1, 32'h55, 32'h66}) begin
      fails++;
      $display("FAIL relaunch_launch: done=%b start=%b a=%h b=%h want 0 1 00000055 00000066",
               done_o, fpga_start_o, fpga_op_a_o, fpga_op_b_o);
    end
    tick();
    fpga_done_i  = 1'b1;
    fpga_res_a_i = 32'h77;
    fpga_res_b_i = 32'h88;
    fpga_res_c_i = 32'h99;
    exp_q.push_back('{a: 32'h77, b: 32'h88, c: 32'h99, to: 1'b0});
    tick();
    fpga_done_i = 1'b0;
    tests++;
    if (exp_q.size() == 0 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL relaunch_done: done=%b queue=%0d want 1 1", done_o, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({result_a_o, result_b_o, result_c_o, timeout_o} !== {e.a, e.b, e.c, e.to}) begin
        fails++;
        $display("FAIL relaunch_results: got %h %h %h to=%b want %h %h %h to=%b",
                 result_a_o, result_b_o, result_c_o, timeout_o, e.a, e.b, e.c, e.to);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    strobe(2'd2, 32'hDEAD_0001, 32'hDEAD_0002);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({fpga_start_o, done_o, busy_o, timeout_o, overrun_o, fpga_operator_o,
         fpga_op_a_o, fpga_op_b_o, result_a_o, result_b_o, result_c_o} !== '0) begin
      fails++;
      $display("FAIL midwait_reset: st=%b dn=%b bz=%b to=%b ov=%b a=%h ra=%h want all 0",
               fpga_start_o, done_o, busy_o, timeout_o, overrun_o, fpga_op_a_o, result_a_o);
    end
    fpga_done_i  = 1'b1;
    fpga_res_a_i = 32'hBAD0_0001;
    tick();
    tick();
    fpga_done_i = 1'b0;
    tests++;
    if ({done_o, busy_o, result_a_o} !== {1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL midwait_late_done: done=%b busy=%b ra=%h want 0 0 00000000",
               done_o, busy_o, result_a_o);
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    write_strobe_i   = 1'b0;
    operator_i       = '0;
    operand_a_i      = '0;
    operand_b_i      = '0;
    timeout_cycles_i = '0;
    fpga_done_i      = 1'b0;
    fpga_res_a_i     = '0;
    fpga_res_b_i     = '0;
    fpga_res_c_i     = '0;
    test_reset();
    test_basic();
    test_timeout();
    test_collision();
    test_overrun();
    test_back_to_back();
    test_reset_mid_wait();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
